// File: rtl/mavg_pkg.sv
// Shared defaults, FSM state encoding and the result-tag layout for the
// moving-average session scheduler.
package mavg_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_N     = 16;
  localparam int DEFAULT_NREQ  = 4;
  localparam int DEFAULT_ID_W  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLUSH  = 2'd1,
    STREAM = 2'd2
  } state_t;

  // Travels alongside each filter input so the 1-cycle-late filter output
  // can be attributed to its session.
  typedef struct packed {
    logic                    keep;
    logic [DEFAULT_ID_W-1:0] id;
    logic                    last;
    logic                    partial;
  } tag_t;

endpackage

// File: rtl/mavg_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after last_grant+1.
module mavg_rr_arbiter
  import mavg_pkg::*;
#(
  parameter int NREQ = DEFAULT_NREQ,
  parameter int ID_W = DEFAULT_ID_W
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [ID_W-1:0] i_last_grant,
  output logic [ID_W-1:0] o_grant,
  output logic            o_found
);

  // Scan requesters in rotating order starting just after the last grant
  always_comb begin
    logic [ID_W-1:0] w_idx;
    w_idx   = '0;
    o_grant = '0;
    o_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = ID_W'((int'(i_last_grant) + k) % NREQ);
      if (!o_found && i_req[w_idx]) begin
        o_found = 1'b1;
        o_grant = w_idx;
      end else begin
        o_found = o_found;
      end
    end
  end

endmodule

// File: rtl/mavg_session_scheduler.sv
// Time-shares one moving-average filter between NREQ requesters, one whole
// frame per session, flushing the filter history between sessions and
// returning the kept averages tagged with the owner's id.
module mavg_session_scheduler
  import mavg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N     = DEFAULT_N,
  parameter int NREQ  = DEFAULT_NREQ,
  parameter int ID_W  = DEFAULT_ID_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_sample,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  output logic                  flt_in_valid,
  output logic [WIDTH-1:0]      flt_in_sample,
  input  logic                  flt_out_valid,
  input  logic [WIDTH-1:0]      flt_out_sample,
  output logic                  res_valid,
  output logic [WIDTH-1:0]      res_sample,
  output logic [ID_W-1:0]       res_id,
  output logic                  res_last,
  output logic                  res_partial,
  output logic                  busy
);

  localparam int CNT_W  = $clog2(N);      // flush counter runs 0..N-1
  localparam int SESS_W = $clog2(N) + 1;  // session count saturates at N

  state_t            r_state;
  logic [ID_W-1:0]   r_grant;
  logic [ID_W-1:0]   r_last_grant;
  logic              r_clean;
  logic [CNT_W-1:0]  r_flush_cnt;
  logic [SESS_W-1:0] r_sess_cnt;
  tag_t              r_tag;

  logic [ID_W-1:0]   w_pick;
  logic              w_found;
  logic              w_grant_valid;
  logic              w_grant_last;
  logic [WIDTH-1:0]  w_grant_sample;
  logic              w_accept;
  logic              w_full_hist;
  tag_t              w_tag_next;

  mavg_rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .i_req        (req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_pick),
    .o_found      (w_found)
  );

  assign w_grant_valid  = req_valid[r_grant];
  assign w_grant_last   = req_last[r_grant];
  assign w_grant_sample = req_sample[int'(r_grant)*WIDTH +: WIDTH];
  assign w_accept       = (r_state == STREAM) && w_grant_valid;
  // Once N-1 samples are in, the window holds only this session's data.
  assign w_full_hist    = (r_sess_cnt >= SESS_W'(N - 1));

  // Drive the shared filter input and the per-requester accepts from state
  always_comb begin
    req_ready     = '0;
    flt_in_valid  = 1'b0;
    flt_in_sample = '0;
    case (r_state)
      FLUSH: begin
        flt_in_valid  = 1'b1;
        flt_in_sample = '0;
      end
      STREAM: begin
        req_ready[r_grant] = 1'b1;
        flt_in_valid       = w_grant_valid;
        flt_in_sample      = w_grant_sample;
      end
      default: begin
        flt_in_valid = 1'b0;
      end
    endcase
  end

  // Build the tag for this cycle's filter input; flush and idle cycles are dropped
  always_comb begin
    w_tag_next = '0;
    if (w_accept) begin
      w_tag_next.keep    = w_full_hist | w_grant_last;
      w_tag_next.id      = DEFAULT_ID_W'(r_grant);
      w_tag_next.last    = w_grant_last;
      w_tag_next.partial = w_grant_last & ~w_full_hist;
    end else begin
      w_tag_next = '0;
    end
  end

  // Session FSM: arbitrate, optionally flush history, then stream one frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last_grant <= ID_W'(NREQ - 1);
      r_clean      <= 1'b1;
      r_flush_cnt  <= '0;
      r_sess_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant      <= w_pick;
            r_last_grant <= w_pick;
            r_sess_cnt   <= '0;
            r_flush_cnt  <= '0;
            if (r_clean) begin
              r_state <= STREAM;
            end else begin
              r_state <= FLUSH;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        FLUSH: begin
          if (r_flush_cnt == CNT_W'(N - 1)) begin
            r_clean <= 1'b1;
            r_state <= STREAM;
          end else begin
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
          end
        end
        STREAM: begin
          if (w_accept) begin
            r_clean <= 1'b0;
            if (r_sess_cnt != SESS_W'(N)) begin
              r_sess_cnt <= r_sess_cnt + SESS_W'(1);
            end else begin
              r_sess_cnt <= r_sess_cnt;
            end
            if (w_grant_last) begin
              r_state <= IDLE;
            end else begin
              r_state <= STREAM;
            end
          end else begin
            r_state <= STREAM;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Tag pipeline aligned with the filter's single cycle of latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag <= '0;
    end else begin
      r_tag <= w_tag_next;
    end
  end

  // A partial frame right after reset meets a filter that is not yet warm,
  // so its tag alone qualifies the result.
  assign res_valid   = r_tag.keep & (flt_out_valid | r_tag.partial);
  assign res_sample  = flt_out_sample;
  assign res_id      = ID_W'(r_tag.id);
  assign res_last    = r_tag.last;
  assign res_partial = r_tag.partial;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_mavg_session_scheduler.sv
// Scoreboard bench for mavg_session_scheduler with a behavioural N=16 filter.
module tb_mavg_session_scheduler;

  localparam int WIDTH = 16;
  localparam int N     = 16;
  localparam int NREQ  = 4;
  localparam int ID_W  = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*WIDTH-1:0] req_sample = '0;
  logic [NREQ-1:0]       req_last = '0;
  logic [NREQ-1:0]       req_ready;
  logic                  flt_in_valid;
  logic [WIDTH-1:0]      flt_in_sample;
  logic                  flt_out_valid;
  logic [WIDTH-1:0]      flt_out_sample;
  logic                  res_valid;
  logic [WIDTH-1:0]      res_sample;
  logic [ID_W-1:0]       res_id;
  logic                  res_last;
  logic                  res_partial;
  logic                  busy;

  typedef struct {
    logic signed [WIDTH-1:0] v;
    logic [ID_W-1:0]         id;
    logic                    last;
    logic                    partial;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   last_ids[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_res    = 0;
  int   n_last   = 0;
  logic signed [WIDTH-1:0] last_val = '0;
  logic                    last_partial = 1'b0;

  always #5 clk = ~clk;

  mavg_session_scheduler dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_sample     (req_sample),
    .req_last       (req_last),
    .req_ready      (req_ready),
    .flt_in_valid   (flt_in_valid),
    .flt_in_sample  (flt_in_sample),
    .flt_out_valid  (flt_out_valid),
    .flt_out_sample (flt_out_sample),
    .res_valid      (res_valid),
    .res_sample     (res_sample),
    .res_id         (res_id),
    .res_last       (res_last),
    .res_partial    (res_partial),
    .busy           (busy)
  );

  // Behavioural moving-average filter: 1-cycle latency, valid once N samples seen
  logic signed [WIDTH-1:0] f_hist [N];
  int f_cnt;
  int f_acc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < N; j++) f_hist[j] <= '0;
      f_cnt          <= 0;
      flt_out_valid  <= 1'b0;
      flt_out_sample <= '0;
    end else if (flt_in_valid) begin
      f_acc = int'($signed(flt_in_sample));
      for (int j = 0; j < N - 1; j++) f_acc = f_acc + int'(f_hist[j]);
      for (int j = N - 1; j > 0; j--) f_hist[j] <= f_hist[j-1];
      f_hist[0]      <= flt_in_sample;
      f_cnt          <= (f_cnt < N) ? f_cnt + 1 : f_cnt;
      flt_out_valid  <= (f_cnt + 1 >= N);
      flt_out_sample <= WIDTH'(f_acc >>> 4);
    end else begin
      flt_out_valid <= 1'b0;
    end
  end

  // Result monitor: pop the scoreboard on every kept result
  always @(negedge clk) begin
    if (rst_n && res_valid) begin
      n_res++;
      if (res_last) begin
        n_last++;
        last_ids.push_back(int'(res_id));
      end
      last_val     = res_sample;
      last_partial = res_partial;
      n_checks++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL result_unexpected: got value %0d id %0d last %0d, expected no result",
                 $signed(res_sample), res_id, res_last);
      end else begin
        mon_e = sbq.pop_front();
        if ({res_sample, res_id, res_last, res_partial} !==
            {mon_e.v, mon_e.id, mon_e.last, mon_e.partial}) begin
          n_fail++;
          $display("FAIL result_value: got v=%0d id=%0d last=%0d partial=%0d, expected v=%0d id=%0d last=%0d partial=%0d",
                   $signed(res_sample), res_id, res_last, res_partial,
                   mon_e.v, mon_e.id, mon_e.last, mon_e.partial);
        end
      end
    end
  end

  // Send one frame from requester id; sample i = base + i*step. Optional stall
  // of stall_len cycles before sample index stall_at. Returns flush cycles seen.
  task automatic send_frame(input int id, input int n, input int base, input int step,
                            input int stall_at, input int stall_len, output int n_flush);
    int win [N];
    int sum;
    int guard;
    logic accepted;
    logic signed [WIDTH-1:0] sv;
    exp_t e;
    for (int j = 0; j < N; j++) win[j] = 0;
    n_flush = 0;
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          req_valid[id] = 1'b0;
          @(negedge clk);
          n_checks++;
          if (flt_in_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_flt_in_valid: got %0b, expected 0", flt_in_valid);
          end
          if (s >= 1) begin
            n_checks++;
            if (res_valid !== 1'b0) begin
              n_fail++;
              $display("FAIL stall_res_valid: got %0b, expected 0", res_valid);
            end
          end
          @(posedge clk);
          #1;
        end
      end
      sv = WIDTH'(base + i * step);
      req_valid[id] = 1'b1;
      req_sample[id*WIDTH +: WIDTH] = sv;
      req_last[id] = (i == n - 1);
      accepted = 1'b0;
      guard = 0;
      while (!accepted) begin
        @(negedge clk);
        if (req_ready[id]) begin
          accepted = 1'b1;
        end else if (flt_in_valid && req_ready == '0 && flt_in_sample == '0) begin
          n_flush++;
        end
        guard++;
        if (!accepted && guard > 3000) begin
          n_checks++;
          n_fail++;
          $display("FAIL accept_timeout: requester %0d sample %0d never accepted", id, i);
          req_valid[id] = 1'b0;
          req_last[id]  = 1'b0;
          return;
        end
      end
      for (int j = N - 1; j > 0; j--) win[j] = win[j-1];
      win[0] = int'(sv);
      if (i >= N - 1 || i == n - 1) begin
        sum = 0;
        for (int j = 0; j < N; j++) sum = sum + win[j];
        e.v       = WIDTH'(sum >>> 4);
        e.id      = ID_W'(id);
        e.last    = (i == n - 1);
        e.partial = (i == n - 1) && (i < N - 1);
        sbq.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    req_valid[id] = 1'b0;
    req_last[id]  = 1'b0;
  endtask

  task automatic wait_idle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({req_ready, flt_in_valid, flt_in_sample} !== '0) begin
      n_fail++;
      $display("FAIL reset_filter_side: got ready=%b fiv=%b fis=%h, expected 0", req_ready, flt_in_valid, flt_in_sample);
    end
    n_checks++;
    if ({res_valid, res_sample, res_id, res_last, res_partial} !== '0) begin
      n_fail++;
      $display("FAIL reset_result_side: got rv=%b rs=%h id=%0d, expected 0", res_valid, res_sample, res_id);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b, expected 0", busy);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_long_frame();
    int nf, r0, l0;
    r0 = n_res;
    l0 = n_last;
    send_frame(0, 20, 160, 0, -1, 0, nf);
    wait_idle();
    n_checks++;
    if (nf !== 0) begin
      n_fail++;
      $display("FAIL long_flush_cycles: got %0d, expected 0", nf);
    end
    n_checks++;
    if (n_res - r0 !== 5) begin
      n_fail++;
      $display("FAIL long_result_count: got %0d, expected 5", n_res - r0);
    end
    n_checks++;
    if (n_last - l0 !== 1) begin
      n_fail++;
      $display("FAIL long_last_count: got %0d, expected 1", n_last - l0);
    end
  endtask

  task automatic test_two_frames();
    int nf0, nf1, r0;
    r0 = n_res;
    send_frame(0, 16, 32, 0, -1, 0, nf0);
    wait_idle();
    send_frame(1, 16, -48, 0, -1, 0, nf1);
    wait_idle();
    n_checks++;
    if (nf0 !== 16) begin
      n_fail++;
      $display("FAIL frame0_flush_cycles: got %0d, expected 16", nf0);
    end
    n_checks++;
    if (nf1 !== 16) begin
      n_fail++;
      $display("FAIL frame1_flush_cycles: got %0d, expected 16", nf1);
    end
    n_checks++;
    if (n_res - r0 !== 2) begin
      n_fail++;
      $display("FAIL two_frames_result_count: got %0d, expected 2", n_res - r0);
    end
    n_checks++;
    if (last_val !== -16'sd48) begin
      n_fail++;
      $display("FAIL frame1_value: got %0d, expected -48", last_val);
    end
  endtask

  task automatic test_round_robin();
    int nfa, nfb, nfc;
    send_frame(3, 4, 8, 0, -1, 0, nfa);
    wait_idle();
    last_ids.delete();
    fork
      send_frame(0, 4, 40, 0, -1, 0, nfa);
      send_frame(2, 4, 80, 0, -1, 0, nfb);
      send_frame(3, 4, 120, 0, -1, 0, nfc);
    join
    wait_idle();
    fork
      send_frame(2, 4, 16, 0, -1, 0, nfb);
      send_frame(0, 4, 48, 0, -1, 0, nfa);
    join
    wait_idle();
    n_checks++;
    if (last_ids.size() !== 5) begin
      n_fail++;
      $display("FAIL rr_session_count: got %0d, expected 5", last_ids.size());
    end else begin
      n_checks++;
      if (last_ids[0] !== 0 || last_ids[1] !== 2 || last_ids[2] !== 3) begin
        n_fail++;
        $display("FAIL rr_order_first: got %0d,%0d,%0d, expected 0,2,3", last_ids[0], last_ids[1], last_ids[2]);
      end
      n_checks++;
      if (last_ids[3] !== 0 || last_ids[4] !== 2) begin
        n_fail++;
        $display("FAIL rr_order_second: got %0d,%0d, expected 0,2", last_ids[3], last_ids[4]);
      end
    end
  endtask

  task automatic test_partial();
    int nf, r0;
    r0 = n_res;
    send_frame(1, 4, 64, 0, -1, 0, nf);
    wait_idle();
    n_checks++;
    if (nf !== 16) begin
      n_fail++;
      $display("FAIL partial_flush_cycles: got %0d, expected 16", nf);
    end
    n_checks++;
    if (n_res - r0 !== 1) begin
      n_fail++;
      $display("FAIL partial_result_count: got %0d, expected 1", n_res - r0);
    end
    n_checks++;
    if (last_val !== 16'sd16 || last_partial !== 1'b1) begin
      n_fail++;
      $display("FAIL partial_value: got %0d partial %0b, expected 16 partial 1", last_val, last_partial);
    end
  endtask

  task automatic test_stall();
    int nf, r0;
    r0 = n_res;
    send_frame(2, 20, 100, 1, 16, 5, nf);
    wait_idle();
    n_checks++;
    if (n_res - r0 !== 5) begin
      n_fail++;
      $display("FAIL stall_result_count: got %0d, expected 5", n_res - r0);
    end
  endtask

  task automatic test_reset_mid_flush();
    int nflush, guard, nf, r0;
    nflush = 0;
    guard  = 0;
    req_valid[1] = 1'b1;
    req_sample[1*WIDTH +: WIDTH] = 16'sd7;
    req_last[1]  = 1'b0;
    while (nflush < 7 && guard < 200) begin
      @(negedge clk);
      if (flt_in_valid && req_ready == '0) nflush++;
      guard++;
    end
    n_checks++;
    if (nflush !== 7) begin
      n_fail++;
      $display("FAIL mid_flush_reach: got %0d flush cycles, expected 7", nflush);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, flt_in_valid, flt_in_sample, busy} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got ready=%b fiv=%b fis=%h busy=%b, expected 0", req_ready, flt_in_valid, flt_in_sample, busy);
    end
    n_checks++;
    if ({res_valid, res_sample, res_last, res_partial} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_results: got rv=%b rs=%h last=%b, expected 0", res_valid, res_sample, res_last);
    end
    sbq.delete();
    req_valid = '0;
    req_last  = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    r0 = n_res;
    send_frame(1, 4, 64, 0, -1, 0, nf);
    wait_idle();
    n_checks++;
    if (nf !== 0) begin
      n_fail++;
      $display("FAIL post_reset_flush_cycles: got %0d, expected 0", nf);
    end
    n_checks++;
    if (n_res - r0 !== 1 || last_val !== 16'sd16) begin
      n_fail++;
      $display("FAIL post_reset_partial: got %0d results value %0d, expected 1 result value 16", n_res - r0, last_val);
    end
  endtask

  initial begin
    test_reset();
    test_long_frame();
    test_two_frames();
    test_round_robin();
    test_partial();
    test_stall();
    test_reset_mid_flush();
    n_checks++;
    if (sbq.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending results, expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mavg_session_scheduler.md
Name: mavg_session_scheduler

Overview:
- Time-shares one moving_avg_filter datapath (N=16, WIDTH=16) between NREQ requesters, granting one whole sample frame (session) at a time.
- Arbitration is round-robin.
- Before each session the scheduler flushes the filter history with zero samples, so no sample from one session is averaged with another session's samples.
- It drops the filter's warm-up outputs and returns each kept average tagged with the owning requester's id.

Parameters:
- WIDTH, 16, sample width (signed two's complement)
- N, 16, filter window length; must equal the filter's N
- NREQ, 4, number of requesters (2..8)
- ID_W, 2, requester id width, = clog2(NREQ)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous and active-low; the same net drives the filter's rst_n
- req_valid  in  NREQ  per-requester sample valid; also acts as that requester's bus request
- req_sample  in  NREQ*WIDTH  per-requester sample; requester k occupies bits [k*WIDTH +: WIDTH]
- req_last  in  NREQ  marks the final sample of a frame
- req_ready  out  NREQ  per-requester accept
- flt_in_valid  out  1  to filter in_valid
- flt_in_sample  out  WIDTH  to filter in_sample
- flt_out_valid  in  1  from filter out_valid
- flt_out_sample  in  WIDTH  from filter out_sample
- res_valid  out  1  kept result strobe
- res_sample  out  WIDTH  average value
- res_id  out  ID_W  owning requester
- res_last  out  1  result belongs to the frame's last sample
- res_partial  out  1  frame was shorter than N samples; res_sample averages over zero-padded history
- busy  out  1  state is not IDLE

Behaviour:
- Reset values (asynchronous): state=IDLE, grant=0, last_grant=NREQ-1, clean=1, flush_cnt=0, sess_cnt=0, tag pipeline cleared. All outputs are 0, including req_ready.
- Reset mid-session aborts the session silently, with no res_last.
- States:
  - IDLE: if any req_valid is high, pick the first requester at or after last_grant+1 (modulo NREQ). Register grant and last_grant.
    - If clean=1, go to STREAM.
    - Otherwise go to FLUSH with flush_cnt=0.
  - FLUSH: flt_in_valid=1, flt_in_sample=0 for exactly N cycles. After the N-th cycle set clean=1 and go to STREAM. req_ready is all 0.
  - STREAM:
    - req_ready[grant]=1; all other req_ready bits are 0.
    - flt_in_valid = req_valid[grant] and flt_in_sample = req_sample[grant], both combinational.
    - Each accepted sample increments sess_cnt (saturating at N) and clears clean.
    - When an accepted sample has req_last=1, go to IDLE. The next arbitration starts the following cycle.
- clean is set by reset or by flush completion, and cleared by the first accepted STREAM sample.
- A requester's req_valid in IDLE is a request only; it is not consumed until STREAM.
- A grant holds until that requester's req_last, even if it deasserts req_valid mid-frame (stall, no timeout).
- Tag pipeline: one register stage, matching the filter's 1-cycle latency. Every filter-input cycle loads the tag {keep, id, last, partial}:
  - keep=1 if the cycle is in STREAM and (sess_cnt_before_accept >= N-1, or req_last=1).
  - partial=1 if req_last=1 and sess_cnt_before_accept < N-1.
  - FLUSH cycles load keep=0.
- Output rule: res_valid = flt_out_valid and tag.keep, with res_id, res_last and res_partial taken from the tag. res_sample passes flt_out_sample through.
- Consequence: a result appears one cycle after its sample is accepted.
- Exception: a partial frame issued right after reset, while the filter's count < N, has flt_out_valid=0. In that case res_valid = tag.keep regardless of flt_out_valid, with res_sample = flt_out_sample.
- The filter has no backpressure, so results are not stallable. Downstream must accept res_valid every cycle.

Decomposition:
- Package mavg_pkg: WIDTH, N, NREQ, ID_W defaults; state enum {IDLE, FLUSH, STREAM}; tag struct {keep, id, last, partial}.
- One sub-module: mavg_rr_arbiter (combinational round-robin pick from req vector and last_grant, plus a found flag).

Test Plan:
- Reset, then requester 0 sends 20 samples of 160 -> no flush cycles; 5 results (samples 16..20), each 160 with res_id=0; only the 5th has res_last=1.
- Requester 0 sends 16 samples of 32, then requester 1 sends 16 samples of -48 -> 16 zero-sample flush cycles between the frames, all req_ready low. Results: 32 with id 0, then -48 with id 1; no mixed values.
- Requesters 0, 2 and 3 all hold req_valid from IDLE with last_grant=3 -> session order 0, 2, 3; then 0 again if it re-requests.
- Requester 1 sends a 4-sample frame of 64 after a flush -> exactly one result: 16 (=256/16), res_last=1, res_partial=1.
- Granted requester drops req_valid for 5 cycles mid-frame -> flt_in_valid low for those cycles; no results during the stall; the sequence resumes unchanged.
- Assert rst_n low during FLUSH cycle 7 -> all outputs 0 immediately; the next session skips flush (clean=1).
